// File: rtl/paralelo_serie.sv
// Parallel-to-serial transmitter: a COM sync burst after reset, then data bytes or COM idle fill, MSB first.
// Optional TX_CNT_EN adds a saturating tx_count of accepted data bytes.
module paralelo_serie #(
    parameter logic [7:0] COM_SYM  = 8'hBC,
    parameter int         SYNC_COM = 4
) (
    input  logic        clk32f,
    input  logic        reset,
    input  logic [7:0]  in,
    input  logic        valid,
    output logic        out,
    output logic        ready,
    output logic        active
`ifdef TX_CNT_EN
    ,
    output logic [15:0] tx_count
`endif
);

    typedef enum logic {SYNC, ACTIVE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [3:0]  com_cnt, com_cnt_nxt;
    logic [7:0]  load_sym;
    logic        load;
    logic        take;

    assign load = (bit_cnt == 3'd7);

    // Handshake: ready is high only in the load cycle while ACTIVE; a byte is
    // taken on that edge when valid=1, otherwise COM goes out as idle fill.
    assign ready = (state == ACTIVE) && load;
    assign out   = shreg[7];

    always_comb begin
        state_nxt   = state;
        com_cnt_nxt = com_cnt;
        load_sym    = COM_SYM;
        take        = 1'b0;
        if (load) begin
            case (state)
                SYNC: begin
                    com_cnt_nxt = com_cnt + 4'd1;
                    if (com_cnt == 4'(SYNC_COM - 1))
                        state_nxt = ACTIVE;
                end
                ACTIVE: begin
                    if (valid) begin
                        load_sym = in;
                        take     = 1'b1;
                    end
                end
                default: state_nxt = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state   <= SYNC;
            com_cnt <= 4'd0;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            active  <= 1'b0;
        end else begin
            state   <= state_nxt;
            com_cnt <= com_cnt_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= load ? load_sym : {shreg[6:0], 1'b0};
            // Registered copy of the next state so active rises on the same edge as ACTIVE.
            active  <= (state_nxt == ACTIVE);
        end
    end

`ifdef TX_CNT_EN
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset)
            tx_count <= 16'h0000;
        else if (take && tx_count != 16'hFFFF)
            tx_count <= tx_count + 16'd1;
    end
`else
    logic unused_take;
    assign unused_take = take;
`endif

endmodule
